// File: rtl/fp_pkg.sv
// Shared constants and operand classification for the bfloat16-to-integer converter.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

endpackage

// File: rtl/fp_align.sv
// Bidirectional alignment of the {1,mantissa} significand to an integer magnitude.
// Produces a W+1 bit integer part plus guard (first dropped bit) and sticky (OR of the rest).
// 'big' flags exponents whose magnitude cannot fit W bits, so saturation is certain.
module fp_align #(
    parameter int W = 16
) (
    input  logic               [7:0] sig,
    input  logic signed        [9:0] e,
    output logic               [W:0] mag,
    output logic                     guard,
    output logic                     sticky,
    output logic                     big
);

    int          w_e_i;
    logic [2:0]  w_sh;
    logic [15:0] w_tmp;

    // Shift left for e >= 7, right for 0 <= e < 7, fraction-only below that
    always_comb begin
        w_e_i  = int'(e);
        w_sh   = 3'd0;
        w_tmp  = 16'd0;
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        big    = 1'b0;
        if (w_e_i >= W) begin
            big = 1'b1;
        end else if (w_e_i >= 7) begin
            mag = (W+1)'(sig) << (w_e_i - 7);
        end else if (w_e_i >= 0) begin
            w_sh   = 3'(7 - w_e_i);
            w_tmp  = {sig, 8'd0} >> w_sh;
            mag    = (W+1)'(w_tmp[15:8]);
            guard  = w_tmp[7];
            sticky = |w_tmp[6:0];
        end else if (w_e_i == -1) begin
            // value in [0.5,1): the hidden one is the guard bit
            guard  = 1'b1;
            sticky = |sig[6:0];
        end else begin
            // value in (0,0.5): nonzero, never reaches the guard position
            sticky = 1'b1;
        end
    end

endmodule

// File: rtl/fp2int.sv
// bfloat16-style float to signed W-bit integer, two-stage valid/ready pipeline.
// Stage 1 classifies and aligns; stage 2 rounds, negates and saturates.
// Build option: FP2INT_ROUND_NEAREST_EN selects round-half-to-even; otherwise truncate toward zero.
module fp2int
    import fp_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         invalid,
    output logic         overflow,
    output logic         inexact
);

    logic              w_en;
    logic [EXP_W-1:0]  w_exp;
    logic [MAN_W-1:0]  w_man;
    fp_class_t         w_cls;
    logic signed [9:0] w_e;
    logic [W:0]        w_mag;
    logic              w_guard, w_sticky, w_big;

    logic              r_s1_vld;
    fp_class_t         r_s1_cls;
    logic              r_s1_sign;
    logic [W:0]        r_s1_mag;
    logic              r_s1_guard, r_s1_sticky, r_s1_big, r_s1_mnz;

    logic              w_inc;
    logic [W:0]        w_rmag;
    logic              w_sat;
    logic [W-1:0]      w_satval;
    logic [W-1:0]      w_res;
    logic              w_inv, w_ovf, w_inx;

    // Whole pipeline moves unless the output is held by the consumer
    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    assign w_exp = a[14:7];
    assign w_man = a[6:0];
    assign w_e   = signed'(10'({2'b00, w_exp}) - 10'(BIAS));

    // Operand class from the exponent/mantissa encodings
    always_comb begin
        if (w_exp == '0)
            w_cls = ZERO;
        else if (w_exp == '1)
            w_cls = (w_man == '0) ? INF : NAN;
        else
            w_cls = NORM;
    end

    fp_align #(.W(W)) u_align (
        .sig    ({1'b1, w_man}),
        .e      (w_e),
        .mag    (w_mag),
        .guard  (w_guard),
        .sticky (w_sticky),
        .big    (w_big)
    );

    // Stage 1 register: class, sign and aligned magnitude
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_s1_vld    <= 1'b0;
            r_s1_cls    <= ZERO;
            r_s1_sign   <= 1'b0;
            r_s1_mag    <= '0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_big    <= 1'b0;
            r_s1_mnz    <= 1'b0;
        end else if (w_en) begin
            r_s1_vld    <= in_valid;
            r_s1_cls    <= w_cls;
            r_s1_sign   <= a[N-1];
            r_s1_mag    <= w_mag;
            r_s1_guard  <= w_guard;
            r_s1_sticky <= w_sticky;
            r_s1_big    <= w_big;
            r_s1_mnz    <= |w_man;
        end
    end

`ifdef FP2INT_ROUND_NEAREST_EN
    assign w_inc = r_s1_guard & (r_s1_sticky | r_s1_mag[0]);
`else
    assign w_inc = 1'b0;
`endif

    // Magnitude stays below 2^W before rounding, so W+1 bits hold the carry
    assign w_rmag = r_s1_mag + {{W{1'b0}}, w_inc};

    // Positive limit 2^(W-1)-1; negative limit 2^(W-1) is still representable
    assign w_sat = r_s1_big | w_rmag[W] |
                   (r_s1_sign ? (w_rmag[W-1] & |w_rmag[W-2:0]) : w_rmag[W-1]);
    assign w_satval = r_s1_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    // Stage 2 result and flags per operand class
    always_comb begin
        w_res = '0;
        w_inv = 1'b0;
        w_ovf = 1'b0;
        w_inx = 1'b0;
        case (r_s1_cls)
            ZERO: w_inx = r_s1_mnz;
            NAN:  w_inv = 1'b1;
            INF: begin
                w_res = w_satval;
                w_ovf = 1'b1;
            end
            default: begin
                if (w_sat) begin
                    w_res = w_satval;
                    w_ovf = 1'b1;
                end else begin
                    w_res = r_s1_sign ? -w_rmag[W-1:0] : w_rmag[W-1:0];
                    w_inx = r_s1_guard | r_s1_sticky;
                end
            end
        endcase
    end

    // Output register: held while the consumer stalls
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            result    <= '0;
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            inexact   <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_s1_vld;
            if (r_s1_vld) begin
                result   <= w_res;
                invalid  <= w_inv;
                overflow <= w_ovf;
                inexact  <= w_inx;
            end
        end
    end

endmodule

// File: doc/fp2int.md
FP2INT -- requirements
Module: fp2int

Interface
REQ-001 Parameter N, default 16: float operand width (sign [N-1], exponent [14:7], mantissa [6:0]).
REQ-002 Parameter W, default 16: signed integer result width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 nreset  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  1  operand a valid this cycle.
REQ-006 in_ready  output  1  block accepts a this cycle.
REQ-007 a  input  N  float operand.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 result  output  W  two's-complement integer.
REQ-011 invalid, overflow, inexact  output  1 each  exception flags, qualified by out_valid.

Function
REQ-012 Transfer in occurs on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-013 Two-stage pipeline: stage 1 classify, unbias (e = exp-127), align {1,mant} by left shift e-7 or right shift 7-e with guard/sticky capture; stage 2 round, negate, saturate.
REQ-014 Latency exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput one per cycle.
REQ-015 Pipeline advance enable = ~out_valid | out_ready; in_ready equals advance enable; stall freezes both stages.
REQ-016 While out_valid & ~out_ready, result and flags SHALL stay stable.
REQ-017 exp==0 (zero or denormal): result 0; inexact=1 if mantissa nonzero; sign ignored.
REQ-018 exp==255, mantissa 0 (inf): result 2^(W-1)-1 or -2^(W-1) per sign, overflow=1.
REQ-019 exp==255, mantissa nonzero (NaN): result 0, invalid=1.
REQ-020 e<0: magnitude below 1, result per rounding rule (REQ-026), inexact=1.
REQ-021 Magnitude above 2^(W-1)-1 (positive) or above 2^(W-1) (negative), including after rounding carry: saturate, overflow=1, inexact=0.
REQ-022 Exactly -2^(W-1) SHALL convert without overflow.
REQ-023 inexact=1 whenever any discarded fraction bit is nonzero and no saturation occurs.
REQ-024 Internal magnitude path W+1 bits plus guard and sticky; no silent truncation.

Reset
REQ-025 nreset low: both stage-valid bits, out_valid, result, flags cleared to 0 immediately; in-flight operands discarded; in_ready=1 on first edge after release.

Configuration
REQ-026 Macro FP2INT_ROUND_NEAREST_EN defined: round half to even; undefined: truncate toward zero; flags and saturation identical otherwise.

Structure
REQ-027 Package fp_pkg holds EXP_W=8, MAN_W=7, BIAS=127, and an fp_class_t enum {ZERO, NORM, INF, NAN}.
REQ-028 One sub-module, fp_align, performs the bidirectional shift with guard/sticky output.

Verification
REQ-029 a=0x3F80 (1.0), out_ready=1 -> result 0x0001 two cycles later, no flags.
REQ-030 a=0xC2F6 (-123.0) -> result 0xFF85, no flags.
REQ-031 a=0x3FC0 (1.5), 0x4020 (2.5) -> nearest build 0x0002, 0x0002; truncate build 0x0001, 0x0002; inexact=1 both.
REQ-032 a=0x4780 (65536.0) -> 0x7FFF overflow=1; a=0xC700 (-32768.0) -> 0x8000 no flags; a=0x7FC1 -> 0x0000 invalid=1.
REQ-033 Stream 4 operands back-to-back, out_ready low 3 cycles mid-stream -> in_ready low during stall, outputs held, all 4 results in order, none lost or duplicated.
REQ-034 nreset pulsed with 2 operands in flight -> out_valid 0 immediately, neither result ever emitted.
